// File: rtl/csr_wport_if.sv
// CSR write-port arbiter bus: trap sequencer beats, WB-stage CSR writes, CSR read path and CSR file write port.
// master = requesters/pipeline side, slave = arbiter.
interface csr_wport_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              trap_valid_i;
  logic              trap_last_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic [DATA_W-1:0] trap_data_i;
  logic              trap_ready_o;
  logic              inst_valid_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [DATA_W-1:0] inst_data_i;
  logic              inst_ready_o;
  logic              csr_re_i;
  logic [ADDR_W-1:0] csr_raddr_i;
  logic [DATA_W-1:0] csr_rdata_i;
  logic [DATA_W-1:0] csr_rdata_o;
  logic              raw_hazard_o;
  logic              csr_we_o;
  logic [ADDR_W-1:0] csr_waddr_o;
  logic [DATA_W-1:0] csr_wdata_o;
  logic              stall_o;
  logic              busy_o;

  modport master (
    output trap_valid_i, trap_last_i, trap_addr_i, trap_data_i,
    output inst_valid_i, inst_addr_i, inst_data_i,
    output csr_re_i, csr_raddr_i, csr_rdata_i,
    input  trap_ready_o, inst_ready_o, csr_rdata_o, raw_hazard_o,
    input  csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, busy_o
  );

  modport slave (
    input  trap_valid_i, trap_last_i, trap_addr_i, trap_data_i,
    input  inst_valid_i, inst_addr_i, inst_data_i,
    input  csr_re_i, csr_raddr_i, csr_rdata_i,
    output trap_ready_o, inst_ready_o, csr_rdata_o, raw_hazard_o,
    output csr_we_o, csr_waddr_o, csr_wdata_o, stall_o, busy_o
  );
endinterface

// File: rtl/csr_wport_arbiter.sv
// Sole owner of the CSR file write port: arbitrates trap/xRET bursts against WB-stage CSR writes,
// buffering instruction writes in order. CSR_WBUF_FWD_EN enables read forwarding from the buffer.
module csr_wport_arbiter #(
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  csr_wport_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, DRAIN, TRAP} state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  state_t            state, state_nxt;
  wr_t               mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              full, empty;
  logic              push, pop;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              trap_ready, inst_ready;
  logic              hit;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  // State register and buffer pointers; reset discards any buffered writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: bus.inst_addr_i, data: bus.inst_data_i};
  end

  // Next state and combinational write-port mux.
  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    pop        = 1'b0;
    we         = 1'b0;
    waddr      = '0;
    wdata      = '0;
    trap_ready = 1'b0;
    inst_ready = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          // Draining head keeps a slot free, so a new instruction write always fits.
          pop        = 1'b1;
          we         = 1'b1;
          waddr      = mem[rd_ptr].addr;
          wdata      = mem[rd_ptr].data;
          inst_ready = 1'b1;
          push       = bus.inst_valid_i;
          if (bus.trap_valid_i) state_nxt = DRAIN;
        end else if (bus.inst_valid_i) begin
          we         = 1'b1;
          waddr      = bus.inst_addr_i;
          wdata      = bus.inst_data_i;
          inst_ready = 1'b1;
        end else begin
          inst_ready = 1'b1;
          if (bus.trap_valid_i) begin
            we         = 1'b1;
            waddr      = bus.trap_addr_i;
            wdata      = bus.trap_data_i;
            trap_ready = 1'b1;
            if (!bus.trap_last_i) state_nxt = TRAP;
          end
        end
      end
      DRAIN: begin
        if (!empty) begin
          pop   = 1'b1;
          we    = 1'b1;
          waddr = mem[rd_ptr].addr;
          wdata = mem[rd_ptr].data;
        end
        if (count <= CNT_W'(1)) state_nxt = TRAP;
      end
      TRAP: begin
        inst_ready = !full;
        push       = bus.inst_valid_i && !full;
        if (bus.trap_valid_i) begin
          we         = 1'b1;
          waddr      = bus.trap_addr_i;
          wdata      = bus.trap_data_i;
          trap_ready = 1'b1;
          if (bus.trap_last_i) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CSR_WBUF_FWD_EN
  logic [DATA_W-1:0] fwd_data;

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = bus.csr_rdata_i;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (mem[rd_ptr + PTR_W'(i)].addr == bus.csr_raddr_i)) begin
        hit      = 1'b1;
        fwd_data = mem[rd_ptr + PTR_W'(i)].data;
      end
    end
  end

  assign bus.csr_rdata_o  = fwd_data;
  assign bus.raw_hazard_o = 1'b0;
`else
  always_comb begin
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < count) && (mem[rd_ptr + PTR_W'(i)].addr == bus.csr_raddr_i)) hit = 1'b1;
    end
  end

  assign bus.csr_rdata_o  = bus.csr_rdata_i;
  assign bus.raw_hazard_o = bus.csr_re_i && hit;
`endif

  assign bus.csr_we_o     = we;
  assign bus.csr_waddr_o  = waddr;
  assign bus.csr_wdata_o  = wdata;
  assign bus.trap_ready_o = trap_ready;
  assign bus.inst_ready_o = inst_ready;
  assign bus.stall_o      = bus.inst_valid_i && !inst_ready;
  assign bus.busy_o       = (state != IDLE) || !empty;
endmodule

// File: tb/tb_csr_wport_arbiter.sv
// Directed testbench for csr_wport_arbiter (DEPTH=2): direct writes, trap bursts, buffering, drain, RAW.
module tb_csr_wport_arbiter;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  csr_wport_if #(.ADDR_W(12), .DATA_W(32)) bus ();

  csr_wport_arbiter #(.DEPTH(2), .ADDR_W(12), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic clear_inputs();
    bus.trap_valid_i = 1'b0; bus.trap_last_i = 1'b0;
    bus.trap_addr_i  = '0;   bus.trap_data_i = '0;
    bus.inst_valid_i = 1'b0; bus.inst_addr_i = '0; bus.inst_data_i = '0;
    bus.csr_re_i     = 1'b0; bus.csr_raddr_i = '0; bus.csr_rdata_i = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic trap_beat(input logic [11:0] a, input logic [31:0] d, input logic last);
    bus.trap_valid_i = 1'b1; bus.trap_addr_i = a; bus.trap_data_i = d; bus.trap_last_i = last;
  endtask

  task automatic inst_wr(input logic [11:0] a, input logic [31:0] d);
    bus.inst_valid_i = 1'b1; bus.inst_addr_i = a; bus.inst_data_i = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++; if (bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL reset_we got=%0b exp=0", bus.csr_we_o); end
    checks++; if (bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL reset_inst_ready got=%0b exp=1", bus.inst_ready_o); end
    checks++; if (bus.trap_ready_o !== 1'b0) begin failures++; $display("FAIL reset_trap_ready got=%0b exp=0", bus.trap_ready_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0 || bus.raw_hazard_o !== 1'b0) begin failures++; $display("FAIL reset_flags busy=%0b stall=%0b haz=%0b exp=0", bus.busy_o, bus.stall_o, bus.raw_hazard_o); end
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_direct_write();
    tick();
    inst_wr(12'h340, 32'h55);
    #2;
    checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h340 || bus.csr_wdata_o !== 32'h55) begin failures++; $display("FAIL direct_write we=%0b addr=%h data=%h exp 1/340/55", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o); end
    checks++; if (bus.busy_o !== 1'b0 || bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL direct_busy busy=%0b rdy=%0b exp 0/1", bus.busy_o, bus.inst_ready_o); end
    tick();
    clear_inputs();
    #2;
    checks++; if (bus.busy_o !== 1'b0 || bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL direct_after busy=%0b we=%0b exp 0/0", bus.busy_o, bus.csr_we_o); end
  endtask

  task automatic test_trap_burst();
    logic [11:0] addrs [5];
    logic [31:0] datas [5];
    addrs = '{12'h341, 12'h342, 12'h343, 12'h300, 12'h344};
    datas = '{32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4};
    for (int b = 0; b < 5; b++) begin
      tick();
      clear_inputs();
      trap_beat(addrs[b], datas[b], b == 4);
      if (b == 1) inst_wr(12'h340, 32'hAA);
      #2;
      checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== addrs[b] || bus.csr_wdata_o !== datas[b] || bus.trap_ready_o !== 1'b1) begin failures++; $display("FAIL burst_beat%0d we=%0b addr=%h data=%h rdy=%0b exp addr=%h data=%h", b, bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o, bus.trap_ready_o, addrs[b], datas[b]); end
      if (b == 1) begin
        checks++; if (bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL burst_inst_accept got=%0b exp=1", bus.inst_ready_o); end
      end
    end
    tick();
    clear_inputs();
    #2;
    checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h340 || bus.csr_wdata_o !== 32'hAA || bus.trap_ready_o !== 1'b0) begin failures++; $display("FAIL burst_drain we=%0b addr=%h data=%h exp 1/340/aa", bus.csr_we_o, bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    #2;
    checks++; if (bus.busy_o !== 1'b0 || bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL burst_end busy=%0b we=%0b exp 0/0", bus.busy_o, bus.csr_we_o); end
  endtask

  task automatic test_buffer_full();
    tick();
    clear_inputs();
    trap_beat(12'h341, 32'h1000, 1'b0);
    tick();
    clear_inputs();
    inst_wr(12'h340, 32'h1);
    #2;
    checks++; if (bus.inst_ready_o !== 1'b1 || bus.csr_we_o !== 1'b0) begin failures++; $display("FAIL full_push1 rdy=%0b we=%0b exp 1/0", bus.inst_ready_o, bus.csr_we_o); end
    tick();
    inst_wr(12'h341, 32'h2);
    #2;
    checks++; if (bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL full_push2 rdy=%0b exp=1", bus.inst_ready_o); end
    tick();
    inst_wr(12'h342, 32'h3);
    #2;
    checks++; if (bus.stall_o !== 1'b1 || bus.inst_ready_o !== 1'b0) begin failures++; $display("FAIL full_stall stall=%0b rdy=%0b exp 1/0", bus.stall_o, bus.inst_ready_o); end
    tick();
    trap_beat(12'h300, 32'h9, 1'b1);
    #2;
    checks++; if (bus.stall_o !== 1'b1 || bus.csr_waddr_o !== 12'h300 || bus.csr_wdata_o !== 32'h9) begin failures++; $display("FAIL full_last stall=%0b addr=%h data=%h exp 1/300/9", bus.stall_o, bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    bus.trap_valid_i = 1'b0; bus.trap_last_i = 1'b0;
    #2;
    checks++; if (bus.stall_o !== 1'b0 || bus.csr_waddr_o !== 12'h340 || bus.csr_wdata_o !== 32'h1) begin failures++; $display("FAIL full_pop1 stall=%0b addr=%h data=%h exp 0/340/1", bus.stall_o, bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    clear_inputs();
    #2;
    checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h341 || bus.csr_wdata_o !== 32'h2) begin failures++; $display("FAIL full_pop2 addr=%h data=%h exp 341/2", bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    #2;
    checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h342 || bus.csr_wdata_o !== 32'h3) begin failures++; $display("FAIL full_pop3 addr=%h data=%h exp 342/3", bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    #2;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL full_end busy=%0b exp=0", bus.busy_o); end
  endtask

  task automatic test_drain();
    tick();
    clear_inputs();
    trap_beat(12'h341, 32'h2000, 1'b0);
    tick();
    clear_inputs();
    inst_wr(12'h340, 32'hA1);
    tick();
    inst_wr(12'h343, 32'hA2);
    tick();
    clear_inputs();
    trap_beat(12'h342, 32'hB, 1'b1);
    tick();
    trap_beat(12'h300, 32'hC0, 1'b1);
    #2;
    checks++; if (bus.trap_ready_o !== 1'b0 || bus.csr_waddr_o !== 12'h340 || bus.csr_wdata_o !== 32'hA1) begin failures++; $display("FAIL drain_c1 trdy=%0b addr=%h data=%h exp 0/340/a1", bus.trap_ready_o, bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    inst_wr(12'h305, 32'h77);
    #2;
    checks++; if (bus.inst_ready_o !== 1'b0 || bus.stall_o !== 1'b1 || bus.trap_ready_o !== 1'b0) begin failures++; $display("FAIL drain_c2_ctl irdy=%0b stall=%0b trdy=%0b exp 0/1/0", bus.inst_ready_o, bus.stall_o, bus.trap_ready_o); end
    checks++; if (bus.csr_waddr_o !== 12'h343 || bus.csr_wdata_o !== 32'hA2) begin failures++; $display("FAIL drain_c2_data addr=%h data=%h exp 343/a2", bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    #2;
    checks++; if (bus.trap_ready_o !== 1'b1 || bus.csr_waddr_o !== 12'h300 || bus.csr_wdata_o !== 32'hC0 || bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL drain_c3 trdy=%0b irdy=%0b addr=%h data=%h exp 1/1/300/c0", bus.trap_ready_o, bus.inst_ready_o, bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    clear_inputs();
    #2;
    checks++; if (bus.csr_we_o !== 1'b1 || bus.csr_waddr_o !== 12'h305 || bus.csr_wdata_o !== 32'h77) begin failures++; $display("FAIL drain_tail addr=%h data=%h exp 305/77", bus.csr_waddr_o, bus.csr_wdata_o); end
    tick();
    #2;
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL drain_end busy=%0b exp=0", bus.busy_o); end
  endtask

  task automatic test_same_cycle();
    tick();
    clear_inputs();
    inst_wr(12'h305, 32'h1);
    trap_beat(12'h341, 32'h2, 1'b1);
    #2;
    checks++; if (bus.csr_waddr_o !== 12'h305 || bus.trap_ready_o !== 1'b0 || bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL same_inst addr=%h trdy=%0b irdy=%0b exp 305/0/1", bus.csr_waddr_o, bus.trap_ready_o, bus.inst_ready_o); end
    tick();
    bus.inst_valid_i = 1'b0;
    #2;
    checks++; if (bus.csr_waddr_o !== 12'h341 || bus.csr_wdata_o !== 32'h2 || bus.trap_ready_o !== 1'b1) begin failures++; $display("FAIL same_trap addr=%h data=%h trdy=%0b exp 341/2/1", bus.csr_waddr_o, bus.csr_wdata_o, bus.trap_ready_o); end
    tick();
    clear_inputs();
  endtask

  task automatic test_raw_and_reset();
    tick();
    trap_beat(12'h341, 32'h3000, 1'b0);
    tick();
    clear_inputs();
    inst_wr(12'h340, 32'h11);
    tick();
    inst_wr(12'h340, 32'h22);
    tick();
    clear_inputs();
    bus.csr_re_i = 1'b1; bus.csr_raddr_i = 12'h340; bus.csr_rdata_i = 32'hDEAD;
    #2;
`ifdef CSR_WBUF_FWD_EN
    checks++; if (bus.csr_rdata_o !== 32'h22 || bus.raw_hazard_o !== 1'b0) begin failures++; $display("FAIL raw_fwd rdata=%h haz=%0b exp 22/0", bus.csr_rdata_o, bus.raw_hazard_o); end
`else
    checks++; if (bus.csr_rdata_o !== 32'hDEAD || bus.raw_hazard_o !== 1'b1) begin failures++; $display("FAIL raw_hazard rdata=%h haz=%0b exp dead/1", bus.csr_rdata_o, bus.raw_hazard_o); end
`endif
    bus.csr_raddr_i = 12'h341;
    #1;
    checks++; if (bus.csr_rdata_o !== 32'hDEAD || bus.raw_hazard_o !== 1'b0) begin failures++; $display("FAIL raw_miss rdata=%h haz=%0b exp dead/0", bus.csr_rdata_o, bus.raw_hazard_o); end
    bus.csr_re_i = 1'b0; bus.csr_raddr_i = 12'h340;
    #1;
    checks++; if (bus.raw_hazard_o !== 1'b0) begin failures++; $display("FAIL raw_no_re haz=%0b exp=0", bus.raw_hazard_o); end
    tick();
    rst = 1'b1;
    clear_inputs();
    #2;
    checks++; if (bus.csr_we_o !== 1'b0 || bus.busy_o !== 1'b0) begin failures++; $display("FAIL midrst we=%0b busy=%0b exp 0/0", bus.csr_we_o, bus.busy_o); end
    tick();
    rst = 1'b0;
    tick();
    #2;
    checks++; if (bus.csr_we_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.inst_ready_o !== 1'b1) begin failures++; $display("FAIL postrst we=%0b busy=%0b irdy=%0b exp 0/0/1", bus.csr_we_o, bus.busy_o, bus.inst_ready_o); end
  endtask

  initial begin
    test_reset();
    test_direct_write();
    test_trap_burst();
    test_buffer_full();
    test_drain();
    test_same_cycle();
    test_raw_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
